// File: rtl/cu_param_pkg.sv
// Shared definitions for the pot-to-register bank fabric: default sizes,
// reload-scan state encoding, index width helper and power-up defaults.
// Optional build macro: CU_PARAM_DEFAULTS_EN -- when defined, tracked pot
// values and bank outputs reset to the POT_DEFAULTS table instead of zero.
package cu_param_pkg;

  localparam int POT_W_DEF     = 10;
  localparam int NUM_POTS_DEF  = 7;
  localparam int NUM_BANKS_DEF = 7;
  localparam int HYST_DEF      = 4;

  // Width of the values returned by pot_default(); callers cast to POT_W.
  localparam int DEF_W = 16;

`ifdef CU_PARAM_DEFAULTS_EN
  localparam bit DEFAULTS_EN = 1'b1;
`else
  localparam bit DEFAULTS_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Power-up musical defaults, [bank][pot].
  // bank 0 oscillator, 1 filter (cutoff mid-scale), 2 ADSR (sustain full),
  // 3 effects, 4..6 spare.
  localparam logic [9:0] POT_DEFAULTS [0:6][0:6] = '{
    '{10'd512, 10'd0,   10'd512, 10'd256, 10'd0,   10'd0,   10'd0},
    '{10'd512, 10'd0,   10'd256, 10'd0,   10'd0,   10'd0,   10'd0},
    '{10'd0,   10'd200, 10'd1023,10'd300, 10'd0,   10'd0,   10'd0},
    '{10'd0,   10'd512, 10'd128, 10'd0,   10'd0,   10'd0,   10'd0},
    '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0},
    '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0},
    '{10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0}
  };

  // Scan index width; at least one bit even for a single bank.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default value for bank/pot; positions outside the table default to zero.
  function automatic logic [DEF_W-1:0] pot_default(input int bank, input int pot);
    if (bank >= 0 && bank < NUM_BANKS_DEF && pot >= 0 && pot < NUM_POTS_DEF) begin
      return {6'd0, POT_DEFAULTS[3'(bank)][3'(pot)]};
    end else begin
      return 16'd0;
    end
  endfunction

endpackage

// File: rtl/cu_pot_hyst.sv
// Single potentiometer front end: input capture register followed by a
// hysteresis tracker. The tracker follows the capture only for moves larger
// than HYST LSBs, but always snaps to either rail so 0 and full scale stay
// reachable despite the dead band.
module cu_pot_hyst #(
  parameter int               POT_W   = 10,
  parameter int               HYST    = 4,
  parameter logic [POT_W-1:0] RST_VAL = {POT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POT_W-1:0] pot_raw,
  output logic [POT_W-1:0] tracked
);

  localparam logic signed [POT_W:0] HYST_POS = (POT_W + 1)'(HYST);
  localparam logic signed [POT_W:0] HYST_NEG = -HYST_POS;
  localparam logic [POT_W-1:0]      POT_MIN  = {POT_W{1'b0}};
  localparam logic [POT_W-1:0]      POT_MAX  = {POT_W{1'b1}};

  logic [POT_W-1:0]        capture_r;
  logic [POT_W-1:0]        tracked_r;
  logic signed [POT_W:0]   diff_s;
  logic                    update_s;

  // Decide whether the tracked value follows the captured sample this cycle.
  always_comb begin
    diff_s   = $signed({1'b0, capture_r}) - $signed({1'b0, tracked_r});
    update_s = 1'b0;
    if (diff_s > HYST_POS || diff_s < HYST_NEG) begin
      update_s = 1'b1;
    end else if ((capture_r == POT_MIN || capture_r == POT_MAX) && capture_r != tracked_r) begin
      update_s = 1'b1;
    end else begin
      update_s = 1'b0;
    end
  end

  // Register the raw Arduino bus every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_r <= RST_VAL;
    end else begin
      capture_r <= pot_raw;
    end
  end

  // Hysteresis tracker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tracked_r <= RST_VAL;
    end else if (update_s) begin
      tracked_r <= capture_r;
    end else begin
      tracked_r <= tracked_r;
    end
  end

  assign tracked = tracked_r;

endmodule

// File: rtl/cu_param_bank.sv
// Pot-to-register fabric: NUM_POTS hysteresis-filtered pots latched into
// NUM_BANKS enable-gated banks, with per-bank change strobes and a sequenced
// reload-all scan triggered by the rising edge of reload_all.
// Optional build macro: CU_PARAM_DEFAULTS_EN -- reset to package defaults.
module cu_param_bank
  import cu_param_pkg::*;
#(
  parameter int NUM_POTS  = NUM_POTS_DEF,
  parameter int POT_W     = POT_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int HYST      = HYST_DEF
) (
  input  logic                              clk50Mhz,
  input  logic                              RESET_N,
  input  logic [NUM_POTS*POT_W-1:0]         pot_in,
  input  logic [NUM_BANKS-1:0]              bank_en,
  input  logic                              reload_all,
  output logic [NUM_BANKS*NUM_POTS*POT_W-1:0] bank_out,
  output logic [NUM_BANKS-1:0]              bank_changed,
  output logic                              busy,
  output logic                              reload_done
);

  localparam int IDX_W  = idx_width(NUM_BANKS);
  localparam int BANK_W = NUM_POTS * POT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

  // Reset value of one pot slot: package default or zero.
  function automatic logic [POT_W-1:0] pot_reset(input int b, input int p);
    return DEFAULTS_EN ? POT_W'(pot_default(b, p)) : {POT_W{1'b0}};
  endfunction

  // Reset value of a whole bank word.
  function automatic logic [BANK_W-1:0] bank_reset(input int b);
    logic [BANK_W-1:0] v;
    v = {BANK_W{1'b0}};
    for (int p = 0; p < NUM_POTS; p++) begin
      v[p*POT_W +: POT_W] = pot_reset(b, p);
    end
    return v;
  endfunction

  logic [BANK_W-1:0]    tracked_s;
  logic [NUM_BANKS-1:0] scan_sel_s;
  logic [NUM_BANKS-1:0] load_s;

  scan_state_t          state_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 reload_q_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 rise_s;

  // Pot front ends. The shared tracked value has no bank of its own, so it
  // powers up with bank 0's defaults.
  for (genvar p = 0; p < NUM_POTS; p++) begin : g_pot
    cu_pot_hyst #(
      .POT_W   (POT_W),
      .HYST    (HYST),
      .RST_VAL (pot_reset(0, p))
    ) u_hyst (
      .clk     (clk50Mhz),
      .rst_n   (RESET_N),
      .pot_raw (pot_in[p*POT_W +: POT_W]),
      .tracked (tracked_s[p*POT_W +: POT_W])
    );
  end

  assign rise_s = reload_all & ~reload_q_r;

  // Delay register for reload_all rising-edge detection.
  always_ff @(posedge clk50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      reload_q_r <= 1'b0;
    end else begin
      reload_q_r <= reload_all;
    end
  end

  // Reload scanner: one bank per cycle, restartable by a fresh rising edge.
  always_ff @(posedge clk50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= SCAN;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (rise_s) begin
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
          end else if (idx_r == LAST_IDX) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IDX_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign reload_done = done_r;

  // Banks: an enable and a scan hit on the same cycle merge into one load.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [BANK_W-1:0] BANK_RST = bank_reset(b);

    logic [BANK_W-1:0] bank_r;
    logic              changed_r;

    assign scan_sel_s[b] = (state_r == SCAN) && (idx_r == IDX_W'(b));
    assign load_s[b]     = bank_en[b] | scan_sel_s[b];

    // Latch tracked values; scan loads always strobe to force a re-latch.
    always_ff @(posedge clk50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
        bank_r    <= BANK_RST;
        changed_r <= 1'b0;
      end else if (load_s[b]) begin
        bank_r    <= tracked_s;
        changed_r <= scan_sel_s[b] | (tracked_s != bank_r);
      end else begin
        bank_r    <= bank_r;
        changed_r <= 1'b0;
      end
    end

    assign bank_out[b*BANK_W +: BANK_W] = bank_r;
    assign bank_changed[b]              = changed_r;
  end

endmodule
